relu_maxpool_2x2: RTL and testbench
===================================

Name: relu_maxpool_2x2

Overview:
- Downstream consumer of the accumulator stage in each convolution lane.
- Takes the stream of finished accumulator results (one per output pixel, raster order) and applies ReLU.
- Performs 2x2 stride-2 max pooling and emits one pooled value per 2x2 window.
- Feeds the next layer's input buffer. No backpressure: the producer pushes, this block never stalls.

Parameters:
- DATA_WIDTH, 32, width of every data word.
- ARITH_TYPE, 1, 1 = IEEE-754 single float, 0 = signed two's-complement fixed point. Kept for uniform instantiation with the adder path; sign is the MSB in both encodings.
- IMG_WIDTH, 28, pixels per input row; must be even, else elaboration error.
- IMG_HEIGHT, 28, rows per input frame; must be even, else elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort: counters to zero, in-flight window discarded.
- in_valid  in  1  in_data carries one accumulated pixel this cycle.
- in_data  in  DATA_WIDTH  accumulated pixel value.
- out_valid  out  1  one-cycle pulse: out_data holds a pooled value.
- out_data  out  DATA_WIDTH  pooled value; holds last value between pulses.
- frame_done  out  1  one-cycle pulse coincident with the out_valid of the last window of a frame.

Behaviour:
- Reset (async, active-high) clears col_cnt, row_cnt, h_reg, out_data, out_valid and frame_done to 0. The row buffer is not reset; every entry is written before it is read.
- ReLU: r = 0 if in_data[DATA_WIDTH-1] = 1, else in_data. Negative zero (0x80000000) maps to 0.
- Compare: after ReLU both encodings are non-negative, so max is an unsigned compare of the full word. No float comparator is needed.
- Counters:
  - col_cnt 0..IMG_WIDTH-1 and row_cnt 0..IMG_HEIGHT-1 advance only on in_valid.
  - col wraps to 0 and increments row; row wraps to 0 after the last pixel.
  - Gaps in in_valid of any length are allowed and change nothing.
- Even column: h_reg <= r.
- Odd column: pair = max(h_reg, r).
  - Even row: rowbuf[col_cnt>>1] <= pair. Depth is IMG_WIDTH/2.
  - Odd row: out_data <= max(rowbuf[col_cnt>>1], pair) and out_valid <= 1.
- Latency: out_valid rises exactly 1 cycle after the in_valid beat at (odd row, odd col). Throughput is 1 input per cycle sustained.
- frame_done is asserted with out_valid when that beat is at (IMG_HEIGHT-1, IMG_WIDTH-1). The counters wrap on the same edge, and the next frame may start on the next cycle with no bubble.
- clear:
  - Takes priority over in_valid in the same cycle; that beat is dropped.
  - Forces out_valid = 0 and frame_done = 0 next cycle.
  - out_data is held.
- Reset mid-frame: identical to clear, plus out_data goes to 0 and h_reg goes to 0.
- Outputs per frame: exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2) out_valid pulses, in pooled raster order.

Decomposition:
- Shared package: ARITH_FLOAT / ARITH_FIXED encoding constants and the LeNet layer geometry constants (28/10 conv output sizes).
- One natural sub-module, pool_row_buffer: a single-port-per-side array, depth IMG_WIDTH/2, one write and one read per cycle, combinational read. Everything else (counters, ReLU, compare) lives in the top.

Test Plan:
- 4x4 fixed-point case (ARITH_TYPE=0, IMG_WIDTH=IMG_HEIGHT=4):
  - Stimulus rows: [1,5,-3,2] [4,-7,8,0] [-1,-2,-3,-4] [-5,-6,-7,-8], in_valid continuous.
  - Expected out: 5, 8, 0, 0, each 1 cycle after its odd-row/odd-col beat.
  - frame_done with the 4th output.
- Float case (ARITH_TYPE=1), window {0xC0400000, 0x3F800000, 0x40000000, 0x80000000} -> out_data 0x40000000. An all-negative window -> 0x00000000.
- Same 4x4 stimulus with random 0-3 cycle gaps between in_valid beats -> identical output values and order. No out_valid at any other time.
- Two back-to-back frames with no bubble -> 8 pulses and 2 frame_done pulses. The second frame's results are not contaminated by the first frame's rowbuf.
- Assert clear after 6 pixels, then send a full 4x4 frame -> exactly 4 outputs, matching the first scenario.
- Assert reset after 9 pixels of a 28x28 frame, then send a full 28x28 frame -> 196 outputs. Outputs are checked against a reference model, and out_data reads 0 immediately after reset.

Source files
------------

// File: rtl/relu_maxpool_2x2_pkg.sv
// Shared constants for the ReLU + 2x2 max-pool stage.
// Holds the arithmetic encodings and the LeNet layer geometry.
package relu_maxpool_2x2_pkg;

    localparam int ARITH_FIXED  = 0;
    localparam int ARITH_FLOAT  = 1;

    localparam int LENET_C1_OUT = 28;
    localparam int LENET_C3_OUT = 10;

endpackage

// File: rtl/relu_maxpool_2x2_pool_row_buffer.sv
// Holds horizontal pair maxima from an even row until the odd row reads them.
// One synchronous write port and one combinational read port.
module pool_row_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 14,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster pixel stream.
// Never stalls; emits one pooled value per window.
module relu_maxpool_2x2
    import relu_maxpool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = ARITH_FLOAT,
    parameter int IMG_WIDTH  = LENET_C1_OUT,
    parameter int IMG_HEIGHT = LENET_C1_OUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done
);

    localparam int CW    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DEPTH = IMG_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
        $error("relu_maxpool_2x2: IMG_WIDTH must be even");
    end
    if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
        $error("relu_maxpool_2x2: IMG_HEIGHT must be even");
    end
    if (ARITH_TYPE != ARITH_FIXED && ARITH_TYPE != ARITH_FLOAT) begin : g_bad_arith
        $error("relu_maxpool_2x2: ARITH_TYPE must be 0 or 1");
    end

    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;
    logic [DATA_WIDTH-1:0] h_reg_q, h_reg_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] relu_val;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] pool_max;
    logic [DATA_WIDTH-1:0] rb_rdata;
    logic [AW-1:0]         rb_addr;
    logic                  rb_we;
    logic                  last_col;
    logic                  last_row;

    // Sign bit is the MSB in both encodings, and once negatives are zeroed
    // an unsigned word compare orders floats and fixed-point alike.
    assign relu_val = in_data[DATA_WIDTH-1] ? '0 : in_data;
    assign pair_max = (h_reg_q > relu_val) ? h_reg_q : relu_val;
    assign pool_max = (rb_rdata > pair_max) ? rb_rdata : pair_max;
    assign rb_addr  = AW'(col_cnt_q >> 1);
    assign last_col = (col_cnt_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_cnt_q == RW'(IMG_HEIGHT - 1));

    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        h_reg_d      = h_reg_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        rb_we        = 1'b0;

        if (clear) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (in_valid) begin
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            if (!col_cnt_q[0]) begin
                h_reg_d = relu_val;
            end else if (!row_cnt_q[0]) begin
                rb_we = 1'b1;
            end else begin
                out_data_d   = pool_max;
                out_valid_d  = 1'b1;
                frame_done_d = last_col && last_row;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            h_reg_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            h_reg_q      <= h_reg_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    pool_row_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_row_buffer (
        .clk   (clk),
        .we    (rb_we),
        .waddr (rb_addr),
        .wdata (pair_max),
        .raddr (rb_addr),
        .rdata (rb_rdata)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2: 4x4 fixed/float instances and a
// 28x28 instance checked against a windowed reference model.
module tb_relu_maxpool_2x2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        ov_fix, ov_flt, fd_fix, fd_flt;
    logic [31:0] od_fix, od_flt;

    logic        clear28;
    logic        in_valid28;
    logic [31:0] in_data28;
    logic        ov28, fd28;
    logic [31:0] od28;

    int total = 0;
    int bad   = 0;

    int          bc, br;
    logic [31:0] exp_q[$];
    logic [31:0] held;
    int          pulses, fds;

    int          c28, r28, seed28;
    logic [31:0] held28;
    int          pulses28, fds28;

    logic [31:0] fa[16];
    logic [31:0] fb[16];
    logic [31:0] ff[16];

    relu_maxpool_2x2 #(
        .DATA_WIDTH (32), .ARITH_TYPE (0),
        .IMG_WIDTH  (4),  .IMG_HEIGHT (4)
    ) u_fix (
        .clk (clk), .reset (reset), .clear (clear),
        .in_valid (in_valid), .in_data (in_data),
        .out_valid (ov_fix), .out_data (od_fix),
        .frame_done (fd_fix)
    );

    relu_maxpool_2x2 #(
        .DATA_WIDTH (32), .ARITH_TYPE (1),
        .IMG_WIDTH  (4),  .IMG_HEIGHT (4)
    ) u_flt (
        .clk (clk), .reset (reset), .clear (clear),
        .in_valid (in_valid), .in_data (in_data),
        .out_valid (ov_flt), .out_data (od_flt),
        .frame_done (fd_flt)
    );

    relu_maxpool_2x2 #(
        .DATA_WIDTH (32), .ARITH_TYPE (0),
        .IMG_WIDTH  (28), .IMG_HEIGHT (28)
    ) u_big (
        .clk (clk), .reset (reset), .clear (clear28),
        .in_valid (in_valid28), .in_data (in_data28),
        .out_valid (ov28), .out_data (od28),
        .frame_done (fd28)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the 4x4 pair; expectations come from the bench's own
    // position tracking and the hand-computed value queue.
    task automatic step(input logic v, input logic [31:0] d,
                        input logic clr);
        logic ev, efd;
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        #1;
        ev  = 1'b0;
        efd = 1'b0;
        if (clr) begin
            bc = 0;
            br = 0;
        end else if (v) begin
            ev  = (bc % 2 == 1) && (br % 2 == 1);
            efd = (bc == 3) && (br == 3);
            if (bc == 3) begin
                bc = 0;
                br = (br == 3) ? 0 : br + 1;
            end else begin
                bc++;
            end
        end
        if (ev) begin
            if (exp_q.size() > 0) held = exp_q.pop_front();
            else held = 'x;
        end
        pulses += int'(ov_fix);
        fds    += int'(fd_fix);
        chk("fix_valid", 32'(ov_fix), 32'(ev));
        chk("flt_valid", 32'(ov_flt), 32'(ev));
        chk("fix_done", 32'(fd_fix), 32'(efd));
        chk("flt_done", 32'(fd_flt), 32'(efd));
        chk("fix_data", od_fix, held);
        chk("flt_data", od_flt, held);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f[16], input int maxgap);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(maxgap)) step(1'b0, 32'h0, 1'b0);
            step(1'b1, f[i], 1'b0);
        end
    endtask

    function automatic logic [31:0] pix(input int s, input int r,
                                        input int c);
        int v;
        v = ((r * 7 + c * 13 + s * 5) % 41) - 20;
        return 32'(v);
    endfunction

    function automatic int ref_pool(input int s, input int r, input int c);
        int m, v;
        m = 0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = int'(pix(s, r - dr, c - dc));
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic step28(input logic v, input logic [31:0] d);
        logic ev, efd;
        in_valid28 = v;
        in_data28  = d;
        clear28    = 1'b0;
        @(posedge clk);
        #1;
        ev  = 1'b0;
        efd = 1'b0;
        if (v) begin
            ev  = (c28 % 2 == 1) && (r28 % 2 == 1);
            efd = (c28 == 27) && (r28 == 27);
            if (ev) held28 = 32'(ref_pool(seed28, r28, c28));
            if (c28 == 27) begin
                c28 = 0;
                r28 = (r28 == 27) ? 0 : r28 + 1;
            end else begin
                c28++;
            end
        end
        pulses28 += int'(ov28);
        fds28    += int'(fd28);
        chk("big_valid", 32'(ov28), 32'(ev));
        chk("big_done", 32'(fd28), 32'(efd));
        chk("big_data", od28, held28);
        in_valid28 = 1'b0;
    endtask

    task automatic frame28(input int s);
        seed28   = s;
        pulses28 = 0;
        fds28    = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                step28(1'b1, pix(s, r, c));
        chk("big_pulses", 32'(pulses28), 32'd196);
        chk("big_frames", 32'(fds28), 32'd1);
    endtask

    initial begin
        fa = '{32'd1, 32'd5, -32'sd3, 32'd2,
               32'd4, -32'sd7, 32'd8, 32'd0,
               -32'sd1, -32'sd2, -32'sd3, -32'sd4,
               -32'sd5, -32'sd6, -32'sd7, -32'sd8};
        fb = '{32'd0, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0,
               32'd9, 32'd1, 32'd2, 32'd3,
               32'd0, 32'd0, 32'd0, 32'd7};
        ff = '{32'hC0400000, 32'h3F800000, 32'hBF800000, 32'hC1200000,
               32'h40000000, 32'h80000000, 32'h80000000, 32'hFF800000,
               32'h3F000000, 32'h3FC00000, 32'h7F7FFFFF, 32'h00000001,
               32'h3F800000, 32'hBF800000, 32'h80000001, 32'h41200000};

        reset      = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        clear28    = 1'b0;
        in_valid28 = 1'b0;
        in_data28  = '0;
        bc = 0; br = 0; held = '0; pulses = 0; fds = 0;
        c28 = 0; r28 = 0; held28 = '0; seed28 = 0;
        pulses28 = 0; fds28 = 0;

        #12;
        chk("rst_valid", 32'(ov_fix), 32'd0);
        chk("rst_done", 32'(fd_fix), 32'd0);
        chk("rst_data", od_fix, 32'd0);
        chk("rst_big_data", od28, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fixed-point frame, continuous input
        exp_q = '{32'd5, 32'd8, 32'd0, 32'd0};
        pulses = 0; fds = 0;
        send_frame(fa, 0);
        step(1'b0, 32'h0, 1'b0);
        chk("fa_pulses", 32'(pulses), 32'd4);
        chk("fa_frames", 32'(fds), 32'd1);

        // Float frame, incl. negative zero and all-negative window
        exp_q = '{32'h40000000, 32'h0, 32'h3FC00000, 32'h7F7FFFFF};
        send_frame(ff, 0);
        step(1'b0, 32'h0, 1'b0);

        // Same fixed frame with random gaps
        exp_q = '{32'd5, 32'd8, 32'd0, 32'd0};
        pulses = 0;
        send_frame(fa, 3);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk("gap_pulses", 32'(pulses), 32'd4);

        // Back-to-back frames, second overwrites the row buffer
        exp_q = '{32'd5, 32'd8, 32'd0, 32'd0,
                  32'd0, 32'd0, 32'd9, 32'd7};
        pulses = 0; fds = 0;
        send_frame(fa, 0);
        send_frame(fb, 0);
        step(1'b0, 32'h0, 1'b0);
        chk("b2b_pulses", 32'(pulses), 32'd8);
        chk("b2b_frames", 32'(fds), 32'd2);

        // Clear after 6 pixels; the 6th closes window 0 of row pair 0
        exp_q = '{32'd5};
        for (int i = 0; i < 6; i++) step(1'b1, fa[i], 1'b0);
        step(1'b1, 32'h7, 1'b1);
        exp_q = '{32'd5, 32'd8, 32'd0, 32'd0};
        pulses = 0; fds = 0;
        send_frame(fa, 0);
        step(1'b0, 32'h0, 1'b0);
        chk("clr_pulses", 32'(pulses), 32'd4);
        chk("clr_frames", 32'(fds), 32'd1);
        chk("expq_empty", 32'(exp_q.size()), 32'd0);

        // 28x28: full frame, abort by reset after 9 pixels, full frame
        frame28(1);
        seed28 = 2;
        for (int i = 0; i < 9; i++) step28(1'b1, pix(2, 0, i));
        reset = 1'b1;
        #1;
        chk("mid_rst_data", od28, 32'd0);
        chk("mid_rst_valid", 32'(ov28), 32'd0);
        chk("mid_rst_done", 32'(fd28), 32'd0);
        c28 = 0; r28 = 0; held28 = '0;
        @(negedge clk);
        reset = 1'b0;
        frame28(3);
        step28(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
